trace_stream_arbiter: RTL and testbench
=======================================

Name: trace_stream_arbiter

Overview:
- Shares one cpu_checker instance among N_SRC trace-record sources.
- Each source presents a character stream of records framed "^ ... #". The arbiter grants whole records round-robin and forwards them to the checker contiguously, one character per cycle.
- It samples the checker's format_type/error_code after the terminating '#' and returns a tagged result per record.
- It keeps per-source saturating counts of well-formed and erroneous records.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- SRC_W, 2, width of source index (clog2(N_SRC), min 1).
- MAX_LEN, 40, maximum characters forwarded per record, including '^' and '#'; exceeding it aborts the record.
- CNT_W, 8, width of per-source statistic counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cfg_freq  in  16  frequency value passed through to the checker.
- src_valid  in  N_SRC  source i has a character on src_char.
- src_char  in  8*N_SRC  character of source i in bits [8i+7:8i].
- src_ready  out  N_SRC  character of source i consumed this cycle.
- chk_char  out  8  character to checker.
- chk_freq  out  16  equals cfg_freq (combinational).
- chk_format_type  in  2  checker format_type.
- chk_error_code  in  4  checker error_code.
- res_valid  out  1  one-cycle pulse: result fields valid.
- res_src  out  SRC_W  source of the reported record.
- res_format  out  2  sampled format_type; 0 on abort.
- res_error  out  4  sampled error_code; 0 on abort.
- res_abort  out  1  record aborted (stall or overlength).
- ok_cnt  out  CNT_W*N_SRC  per source: records with format!=0 and error==0.
- err_cnt  out  CNT_W*N_SRC  per source: records with format==0, error!=0, or abort.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, FWD, CHECK.
- Reset values:
  - Registers: state=IDLE, grant=0, rr_ptr=0, len=0, all counters 0.
  - Outputs: res_valid=0, res_src=0, res_format=0, res_error=0, res_abort=0, chk_char=8'h00, src_ready=0.
  - Reset mid-record drops the record with no result. The checker sees 8'h00 from the next cycle.
- chk_char is 8'h00 in IDLE and CHECK. The checker treats 8'h00 as a non-'^' character, so it parks the checker in its idle state.
- IDLE:
  - Flush: any source with src_valid=1 and char != "^" gets src_ready=1, and its char is discarded.
  - Candidates are sources with src_valid=1 and char == "^".
  - Winner is the first candidate at or after rr_ptr, searching modulo N_SRC.
  - On a winner: grant<=winner, rr_ptr<=winner+1 mod N_SRC, len<=0, state<=FWD. The '^' is NOT consumed in IDLE (src_ready[winner]=0).
  - No candidate: stay in IDLE.
- FWD:
  - If src_valid[grant]=1: chk_char=src_char[grant], src_ready[grant]=1, len<=len+1. All other src_ready=0.
  - If the forwarded char is "#": state<=CHECK.
  - Overlength: if len+1 == MAX_LEN and char != "#", set abort, state<=CHECK.
  - Stall: if src_valid[grant]=0, chk_char=8'h00, set abort, state<=CHECK. The checker resyncs on the source's next '^'; the remainder of the stalled record is flushed in IDLE.
  - An embedded '^' mid-record is forwarded as data. The checker restarts on it, and that is legal.
- CHECK (exactly one cycle after the last forwarded char):
  - Sample chk_format_type/chk_error_code combinationally. The checker updated on the edge ending the '#' cycle.
  - At the edge: res_valid<=1, res_src<=grant, res_abort<=abort.
  - Fields: res_format<=abort?0:chk_format_type; res_error<=abort?0:chk_error_code.
  - Counters update on the same edge, saturating at all-ones.
  - Then state<=IDLE, abort<=0.
- res_valid is high for exactly one cycle: the cycle after CHECK. The result fields hold their values until the next result.
- Latency: '#' forwarded in cycle t → res_valid in cycle t+2. Minimum record-to-record gap is 2 idle cycles (CHECK, IDLE).
- Ties are resolved only by rr_ptr. A source granted once cannot be granted again while another candidate is waiting.

Test Plan:
- Single record: src0 sends "^10@00003000: $1 <= 0000000a#" with cfg_freq=2, no stalls → res_valid 2 cycles after '#', res_src=0, res_format=1, res_error=0, ok_cnt[0]=1.
- Memory record with errors: src2 sends "^3@00003001: *00003000 <= 12345678#" with cfg_freq=4 → res_format=2, res_error=4'b0111, err_cnt[2]=1.
- Round-robin: src0..src3 all hold "^" at the same cycle, each sending one valid record → grants in order 0,1,2,3. Repeat with rr_ptr=2 → order 2,3,0,1.
- Stall abort: src1 drops src_valid for one cycle after "^5@" → chk_char=00 that cycle; res_abort=1, res_format=0, res_error=0, err_cnt[1]=1. The remainder is flushed and the next "^" is re-arbitrated.
- Overlength: a record of 45 chars with no '#' → abort after exactly MAX_LEN=40 forwarded chars, res_abort=1.
- Reset mid-FWD: assert reset after 6 forwarded chars → no res_valid, counters 0, chk_char=00, and the arbiter accepts a fresh record afterwards.

Source files
------------

// File: rtl/trace_stream_arbiter.sv
// trace_stream_arbiter
//   Lets N_SRC trace-record sources share one cpu_checker. A record is framed
//   "^ ... #". Whole records are granted round-robin and streamed to the
//   checker one character per cycle. The checker verdict is sampled one cycle
//   after the closing '#' and returned as a tagged result. Per-source
//   saturating counters track good and bad records.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   cfg_freq            frequency passed straight through as chk_freq
//   src_valid/src_char  per-source character stream (char i in [8i+7:8i])
//   src_ready           per-source consume strobe
//   chk_char/chk_freq   checker inputs
//   chk_format_type/chk_error_code  checker outputs, sampled in CHECK
//   res_*               one-cycle result pulse plus held result fields
//   ok_cnt/err_cnt      per-source counters, CNT_W bits per source
//   busy                arbiter is not idle

// Per-source statistics: two saturating counters.
module trace_src_stats #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_ok,
  input  logic             inc_err,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  always_ff @(posedge clk) begin
    if (reset) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (inc_ok && ok_cnt != '1)   ok_cnt  <= ok_cnt + CNT_W'(1);
      if (inc_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end
endmodule

module trace_stream_arbiter #(
  parameter int N_SRC   = 4,
  parameter int SRC_W   = 2,
  parameter int MAX_LEN = 40,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            cfg_freq,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [8*N_SRC-1:0]     src_char,
  output logic [N_SRC-1:0]       src_ready,
  output logic [7:0]             chk_char,
  output logic [15:0]            chk_freq,
  input  logic [1:0]             chk_format_type,
  input  logic [3:0]             chk_error_code,
  output logic                   res_valid,
  output logic [SRC_W-1:0]       res_src,
  output logic [1:0]             res_format,
  output logic [3:0]             res_error,
  output logic                   res_abort,
  output logic [CNT_W*N_SRC-1:0] ok_cnt,
  output logic [CNT_W*N_SRC-1:0] err_cnt,
  output logic                   busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FWD   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [7:0] CH_SOR = 8'h5E;  // '^'
  localparam logic [7:0] CH_EOR = 8'h23;  // '#'

  logic [1:0]       state;
  logic [SRC_W-1:0] grant, rr_ptr;
  logic [LEN_W-1:0] len;
  logic             abort;

  logic [N_SRC-1:0][7:0] chars;
  assign chars = src_char;

  assign chk_freq = cfg_freq;
  assign busy     = (state != S_IDLE);

  // Round-robin pick among sources presenting '^'
  logic [N_SRC-1:0] cand;
  logic             found;
  logic [SRC_W-1:0] win;

  always_comb begin
    int idx;
    cand  = '0;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N_SRC; i++)
      cand[i] = src_valid[i] && (chars[i] == CH_SOR);
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % N_SRC;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = SRC_W'(idx);
      end
    end
  end

  // Datapath to sources/checker. Gated by reset so the checker parks on 00
  // and no character is consumed while reset is held.
  logic [7:0] cur_char;
  logic       cur_valid;
  assign cur_char  = chars[grant];
  assign cur_valid = src_valid[grant];

  always_comb begin
    src_ready = '0;
    chk_char  = 8'h00;
    if (!reset) begin
      case (state)
        S_IDLE:
          // Drain stray characters (e.g. tail of a stalled record); keep '^'
          for (int i = 0; i < N_SRC; i++)
            src_ready[i] = src_valid[i] && (chars[i] != CH_SOR);
        S_FWD:
          if (cur_valid) begin
            src_ready[grant] = 1'b1;
            chk_char         = cur_char;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      len        <= '0;
      abort      <= 1'b0;
      res_valid  <= 1'b0;
      res_src    <= '0;
      res_format <= '0;
      res_error  <= '0;
      res_abort  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant  <= win;
            rr_ptr <= (win == SRC_W'(N_SRC - 1)) ? '0 : win + SRC_W'(1);
            len    <= '0;
            state  <= S_FWD;
          end
        end
        S_FWD: begin
          if (cur_valid) begin
            len <= len + LEN_W'(1);
            if (cur_char == CH_EOR) begin
              state <= S_CHECK;
            end else if (len == LEN_W'(MAX_LEN - 1)) begin
              abort <= 1'b1;
              state <= S_CHECK;
            end
          end else begin
            // Source stalled mid-record: the checker has already seen 00
            abort <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          res_valid  <= 1'b1;
          res_src    <= grant;
          res_abort  <= abort;
          res_format <= abort ? 2'd0 : chk_format_type;
          res_error  <= abort ? 4'd0 : chk_error_code;
          abort      <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Record verdict in CHECK, credited to the granted source
  logic rec_ok;
  assign rec_ok = !abort && (chk_format_type != 2'd0) && (chk_error_code == 4'd0);

  for (genvar g = 0; g < N_SRC; g++) begin : g_stats
    logic hit;
    assign hit = (state == S_CHECK) && (grant == SRC_W'(g));
    trace_src_stats #(.CNT_W(CNT_W)) u_stats (
      .clk     (clk),
      .reset   (reset),
      .inc_ok  (hit && rec_ok),
      .inc_err (hit && !rec_ok),
      .ok_cnt  (ok_cnt[g*CNT_W +: CNT_W]),
      .err_cnt (err_cnt[g*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Directed bench for trace_stream_arbiter. Each source is a character FIFO
// filled by the stimulus; the checker verdict is driven directly by the bench.
module tb_trace_stream_arbiter;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int ML = 40;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [15:0]     cfg_freq;
  logic [N-1:0]    src_valid, src_ready;
  logic [8*N-1:0]  src_char;
  logic [7:0]      chk_char;
  logic [15:0]     chk_freq;
  logic [1:0]      chk_format_type;
  logic [3:0]      chk_error_code;
  logic            res_valid, res_abort, busy;
  logic [SW-1:0]   res_src;
  logic [1:0]      res_format;
  logic [3:0]      res_error;
  logic [CW*N-1:0] ok_cnt, err_cnt;

  trace_stream_arbiter #(.N_SRC(N), .SRC_W(SW), .MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_freq(cfg_freq),
    .src_valid(src_valid), .src_char(src_char), .src_ready(src_ready),
    .chk_char(chk_char), .chk_freq(chk_freq),
    .chk_format_type(chk_format_type), .chk_error_code(chk_error_code),
    .res_valid(res_valid), .res_src(res_src), .res_format(res_format),
    .res_error(res_error), .res_abort(res_abort),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  // Source FIFOs
  logic [7:0] mem [N][512];
  int         blen [N];
  int         ptr  [N];
  logic [N-1:0] hold;
  int         cyc;
  int         hash_cyc;
  int         fwd_cnt;

  always_comb begin
    src_valid = '0;
    src_char  = '0;
    for (int i = 0; i < N; i++) begin
      src_valid[i]      = (ptr[i] < blen[i]) && !hold[i];
      src_char[8*i +: 8] = mem[i][ptr[i]];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++)
      if (src_ready[i] === 1'b1) ptr[i] <= ptr[i] + 1;
  end

  // Characters forwarded since the last result, and when '#' went out
  always @(negedge clk) begin
    if (reset || res_valid) fwd_cnt <= 0;
    else if (chk_char != 8'h00) fwd_cnt <= fwd_cnt + 1;
    if (chk_char == 8'h23) hash_cyc <= cyc;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(int i, string s);
    for (int k = 0; k < s.len(); k++) mem[i][blen[i] + k] = s[k];
    blen[i] = blen[i] + s.len();
  endtask

  function automatic logic [CW-1:0] okc(int i);
    return ok_cnt[i*CW +: CW];
  endfunction
  function automatic logic [CW-1:0] errc(int i);
    return err_cnt[i*CW +: CW];
  endfunction

  task automatic expect_res(string tag, int src, int fmt, int err, bit abrt,
                            int n, bit lat);
    bit got = 1'b0;
    int nseen = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        got   = 1'b1;
        nseen = fwd_cnt;
      end
    end
    chk({tag, " seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " src"},    32'(res_src),    32'(src));
      chk({tag, " format"}, 32'(res_format), 32'(fmt));
      chk({tag, " error"},  32'(res_error),  32'(err));
      chk({tag, " abort"},  32'(res_abort),  32'(abrt));
      chk({tag, " nchar"},  32'(nseen),      32'(n));
      if (lat) chk({tag, " latency"}, 32'(cyc - hash_cyc), 32'd2);
      @(negedge clk);
      chk({tag, " pulse"}, 32'(res_valid), 32'd0);
    end
  endtask

  string s_rec  = "^10@00003000: $1 <= 0000000a#";
  string s_mem  = "^3@00003001: *00003000 <= 12345678#";
  string s_stl  = "^5@00003000: $2 <= 00000001#";
  string s_long;

  initial begin
    int base;
    int nres;
    bit hit;
    hold = '0;
    reset = 1'b1;
    cfg_freq = 16'd2;
    chk_format_type = 2'd0;
    chk_error_code = 4'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst res_valid",  32'(res_valid),  32'd0);
    chk("rst res_src",    32'(res_src),    32'd0);
    chk("rst res_format", 32'(res_format), 32'd0);
    chk("rst res_error",  32'(res_error),  32'd0);
    chk("rst res_abort",  32'(res_abort),  32'd0);
    chk("rst chk_char",   32'(chk_char),   32'd0);
    chk("rst src_ready",  32'(src_ready),  32'd0);
    chk("rst busy",       32'(busy),       32'd0);
    chk("rst ok_cnt",     ok_cnt,          32'd0);
    chk("rst err_cnt",    err_cnt,         32'd0);
    chk("chk_freq 2",     32'(chk_freq),   32'd2);
    reset = 1'b0;

    // Single good record on src0
    chk_format_type = 2'd1;
    chk_error_code  = 4'd0;
    load(0, s_rec);
    expect_res("single", 0, 1, 0, 1'b0, 29, 1'b1);
    chk("single ok0", 32'(okc(0)), 32'd1);

    // Memory record with errors on src2
    cfg_freq = 16'd4;
    chk_format_type = 2'd2;
    chk_error_code  = 4'b0111;
    load(2, s_mem);
    expect_res("mem", 2, 2, 7, 1'b0, s_mem.len(), 1'b1);
    chk("mem err2", 32'(errc(2)), 32'd1);
    chk("mem ok2",  32'(okc(2)),  32'd0);
    chk("chk_freq 4", 32'(chk_freq), 32'd4);

    // Stall after "^5@" on src1
    chk_format_type = 2'd1;
    chk_error_code  = 4'd0;
    base = blen[1];
    load(1, s_stl);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (ptr[1] == base + 3) hit = 1'b1;
    end
    chk("stall reached", 32'(hit), 32'd1);
    hold[1] = 1'b1;
    #1;
    chk("stall chk_char",  32'(chk_char),     32'd0);
    chk("stall src_ready", 32'(src_ready[1]), 32'd0);
    @(negedge clk);
    hold[1] = 1'b0;
    expect_res("stall", 1, 0, 0, 1'b1, 3, 1'b0);
    chk("stall err1", 32'(errc(1)), 32'd1);

    // Tail flushed, next '^' on src1 re-arbitrated
    load(1, s_rec);
    expect_res("resync", 1, 1, 0, 1'b0, 29, 1'b1);
    chk("resync ok1", 32'(okc(1)), 32'd1);

    // All four contend, rr_ptr=2
    for (int i = 0; i < N; i++) load(i, s_rec);
    expect_res("rr2 a", 2, 1, 0, 1'b0, 29, 1'b1);
    expect_res("rr2 b", 3, 1, 0, 1'b0, 29, 1'b1);
    expect_res("rr2 c", 0, 1, 0, 1'b0, 29, 1'b1);
    expect_res("rr2 d", 1, 1, 0, 1'b0, 29, 1'b1);

    // Overlength on src3: '^' + 44 chars, no '#'
    s_long = "^";
    for (int k = 0; k < 44; k++) s_long = {s_long, "A"};
    load(3, s_long);
    expect_res("overlen", 3, 0, 0, 1'b1, ML, 1'b0);
    chk("overlen err3", 32'(errc(3)), 32'd1);

    // All four contend, rr_ptr=0
    for (int i = 0; i < N; i++) load(i, s_rec);
    expect_res("rr0 a", 0, 1, 0, 1'b0, 29, 1'b1);
    expect_res("rr0 b", 1, 1, 0, 1'b0, 29, 1'b1);
    expect_res("rr0 c", 2, 1, 0, 1'b0, 29, 1'b1);
    expect_res("rr0 d", 3, 1, 0, 1'b0, 29, 1'b1);
    chk("tot ok0",  32'(okc(0)),  32'd3);
    chk("tot ok1",  32'(okc(1)),  32'd3);
    chk("tot ok2",  32'(okc(2)),  32'd2);
    chk("tot ok3",  32'(okc(3)),  32'd2);
    chk("tot err0", 32'(errc(0)), 32'd0);
    chk("tot err1", 32'(errc(1)), 32'd1);
    chk("tot err2", 32'(errc(2)), 32'd1);
    chk("tot err3", 32'(errc(3)), 32'd1);

    // Reset after 6 forwarded characters
    base = blen[0];
    load(0, s_rec);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (ptr[0] == base + 6) hit = 1'b1;
    end
    chk("rfwd reached", 32'(hit), 32'd1);
    chk("rfwd busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rfwd chk_char in rst",  32'(chk_char),  32'd0);
    chk("rfwd src_ready in rst", 32'(src_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rfwd busy",     32'(busy),     32'd0);
    chk("rfwd chk_char", 32'(chk_char), 32'd0);
    chk("rfwd ok_cnt",   ok_cnt,        32'd0);
    chk("rfwd err_cnt",  err_cnt,       32'd0);
    nres = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) nres++;
    end
    chk("rfwd no result", 32'(nres), 32'd0);
    load(0, s_rec);
    expect_res("fresh", 0, 1, 0, 1'b0, 29, 1'b1);
    chk("fresh ok0", 32'(okc(0)), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
